dmem_arbiter: RTL and testbench

//  Shares the single-port data memory (dmem) between the CPU load/store path and the

---
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Signal bundle linking the CPU load/store path, the CP2 accelerator and the
// single-port dmem through the dmem arbiter.
interface dmem_arbiter_if #(
    parameter int WIDE = 32
);
    logic            cpu_req;
    logic            cpu_we;
    logic [31:0]     cpu_addr;
    logic [WIDE-1:0] cpu_wd;
    logic [WIDE-1:0] cpu_rd;
    logic            cpu_stall;
    logic            cp_req;
    logic            cp_we;
    logic [31:0]     cp_addr;
    logic [WIDE-1:0] cp_wd;
    logic            cp_gnt;
    logic [WIDE-1:0] cp_rd;
    logic            dm_we;
    logic [31:0]     dm_addr;
    logic [WIDE-1:0] dm_d;
    logic [WIDE-1:0] dm_q;
    logic            owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd,
        input  cp_req, cp_we, cp_addr, cp_wd,
        input  dm_q,
        output cpu_rd, cpu_stall, cp_gnt, cp_rd,
        output dm_we, dm_addr, dm_d, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wd,
        output cp_req, cp_we, cp_addr, cp_wd,
        output dm_q,
        input  cpu_rd, cpu_stall, cp_gnt, cp_rd,
        input  dm_we, dm_addr, dm_d, owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port dmem: ownership parks on the CPU, CP2
// takes the port on request, and bounded bursts keep either side from starving.
module dmem_arbiter #(
    parameter int WIDE      = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam int            CW    = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] C_ONE = CW'(1'b1);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_CP  = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cpu_cnt;
    logic [CW-1:0]   r_cp_cnt;

    logic [CW-1:0]   w_cpu_cnt_inc;
    logic [CW-1:0]   w_cp_cnt_inc;
    logic            w_cpu_limit;
    logic            w_cp_limit;
    logic            w_both_req;

    logic            w_own_cp;
    logic            w_dm_we;
    logic [31:0]     w_dm_addr;
    logic [WIDE-1:0] w_dm_d;
    logic            w_cpu_stall;
    logic            w_cp_gnt;

    // A limit is reached when the access granted this cycle completes the owner's burst.
    assign w_cpu_cnt_inc = (r_cpu_cnt == C_MAX) ? C_MAX : (r_cpu_cnt + C_ONE);
    assign w_cp_cnt_inc  = (r_cp_cnt  == C_MAX) ? C_MAX : (r_cp_cnt  + C_ONE);
    assign w_cpu_limit   = (w_cpu_cnt_inc == C_MAX);
    assign w_cp_limit    = (w_cp_cnt_inc  == C_MAX);
    assign w_both_req    = bus.cpu_req & bus.cp_req;

    // Ownership state machine with per-side contention burst counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= OWN_CPU;
            r_cpu_cnt <= {CW{1'b0}};
            r_cp_cnt  <= {CW{1'b0}};
        end else begin
            case (r_state)
                OWN_CPU: begin
                    if (bus.cp_req && (!bus.cpu_req || w_cpu_limit)) begin
                        r_state   <= OWN_CP;
                        r_cp_cnt  <= {CW{1'b0}};
                        r_cpu_cnt <= {CW{1'b0}};
                    end else if (w_both_req) begin
                        r_cpu_cnt <= w_cpu_cnt_inc;
                    end else begin
                        r_cpu_cnt <= {CW{1'b0}};
                    end
                end
                OWN_CP: begin
                    if (!bus.cp_req || (bus.cpu_req && w_cp_limit)) begin
                        r_state   <= OWN_CPU;
                        r_cpu_cnt <= {CW{1'b0}};
                        r_cp_cnt  <= {CW{1'b0}};
                    end else if (w_both_req) begin
                        r_cp_cnt <= w_cp_cnt_inc;
                    end else begin
                        r_cp_cnt <= {CW{1'b0}};
                    end
                end
                default: begin
                    r_state   <= OWN_CPU;
                    r_cpu_cnt <= {CW{1'b0}};
                    r_cp_cnt  <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Port steering: the owner drives dmem in the same cycle, no pipeline stage.
    always_comb begin
        w_own_cp    = 1'b0;
        w_dm_addr   = bus.cpu_addr;
        w_dm_d      = bus.cpu_wd;
        w_dm_we     = bus.cpu_req & bus.cpu_we;
        w_cpu_stall = 1'b0;
        w_cp_gnt    = 1'b0;
        case (r_state)
            OWN_CP: begin
                w_own_cp    = 1'b1;
                w_dm_addr   = bus.cp_addr;
                w_dm_d      = bus.cp_wd;
                w_dm_we     = bus.cp_req & bus.cp_we;
                w_cpu_stall = bus.cpu_req;
                w_cp_gnt    = 1'b1;
            end
            OWN_CPU: begin
                w_own_cp    = 1'b0;
                w_dm_addr   = bus.cpu_addr;
                w_dm_d      = bus.cpu_wd;
                w_dm_we     = bus.cpu_req & bus.cpu_we;
                w_cpu_stall = 1'b0;
                w_cp_gnt    = 1'b0;
            end
            default: begin
                w_own_cp    = 1'b0;
                w_dm_addr   = bus.cpu_addr;
                w_dm_d      = bus.cpu_wd;
                w_dm_we     = 1'b0;
                w_cpu_stall = 1'b0;
                w_cp_gnt    = 1'b0;
            end
        endcase
    end

    // Reset gating kills an in-flight write immediately, without waiting for a clock.
    assign bus.dm_we     = w_dm_we & rst;
    assign bus.dm_addr   = w_dm_addr;
    assign bus.dm_d      = w_dm_d;
    assign bus.cpu_stall = w_cpu_stall & rst;
    assign bus.cp_gnt    = w_cp_gnt & rst;
    assign bus.owner     = w_own_cp & rst;
    assign bus.cpu_rd    = bus.dm_q;
    assign bus.cp_rd     = bus.dm_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MAX_BURST 8 and 1) share one stimulus stream
// and are checked against a wait-count ownership model plus a reference memory image.
module tb_dmem_arbiter;
    logic clk;
    logic rst;
    logic mem_clr;

    dmem_arbiter_if #(.WIDE(32)) b8 ();
    dmem_arbiter_if #(.WIDE(32)) b1 ();

    dmem_arbiter #(.WIDE(32), .MAX_BURST(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
    dmem_arbiter #(.WIDE(32), .MAX_BURST(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    logic [31:0] mem [2][256];
    logic [31:0] ref_mem [2][256];
    logic        m_own [2];
    int          m_wait [2];

    logic        s_rst;
    logic        s_cpu_req, s_cpu_we, s_cp_req, s_cp_we;
    logic [31:0] s_cpu_addr, s_cpu_wd, s_cp_addr, s_cp_wd;
    logic        g_own1;

    int n_checks;
    int n_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural dmem: combinational read, write on the rising edge.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                mem[0][i] <= 32'h0;
                mem[1][i] <= 32'h0;
            end
        end else begin
            if (b8.dm_we) mem[0][b8.dm_addr[9:2]] <= b8.dm_d;
            if (b1.dm_we) mem[1][b1.dm_addr[9:2]] <= b1.dm_d;
        end
    end

    assign b8.dm_q = mem[0][b8.dm_addr[9:2]];
    assign b1.dm_q = mem[1][b1.dm_addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        rst = s_rst;
        b8.cpu_req = s_cpu_req; b8.cpu_we = s_cpu_we; b8.cpu_addr = s_cpu_addr; b8.cpu_wd = s_cpu_wd;
        b8.cp_req  = s_cp_req;  b8.cp_we  = s_cp_we;  b8.cp_addr  = s_cp_addr;  b8.cp_wd  = s_cp_wd;
        b1.cpu_req = s_cpu_req; b1.cpu_we = s_cpu_we; b1.cpu_addr = s_cpu_addr; b1.cpu_wd = s_cpu_wd;
        b1.cp_req  = s_cp_req;  b1.cp_we  = s_cp_we;  b1.cp_addr  = s_cp_addr;  b1.cp_wd  = s_cp_wd;
    endtask

    task automatic check_dut(input int k, input logic own, input logic gnt, input logic stall,
                             input logic we, input logic [31:0] addr, input logic [31:0] d,
                             input logic [31:0] crd, input logic [31:0] prd);
        string       p;
        logic        e_own, e_acc, e_we;
        logic [31:0] e_addr, e_d;
        p = (k == 0) ? "m8" : "m1";
        if (!s_rst) begin
            chk({p, "_rst_owner"}, {31'b0, own}, 32'h0);
            chk({p, "_rst_gnt"},   {31'b0, gnt}, 32'h0);
            chk({p, "_rst_stall"}, {31'b0, stall}, 32'h0);
            chk({p, "_rst_we"},    {31'b0, we}, 32'h0);
        end else begin
            e_own  = m_own[k];
            e_acc  = e_own ? s_cp_req  : s_cpu_req;
            e_we   = e_own ? s_cp_we   : s_cpu_we;
            e_addr = e_own ? s_cp_addr : s_cpu_addr;
            e_d    = e_own ? s_cp_wd   : s_cpu_wd;
            chk({p, "_owner"}, {31'b0, own},   {31'b0, e_own});
            chk({p, "_gnt"},   {31'b0, gnt},   {31'b0, e_own});
            chk({p, "_stall"}, {31'b0, stall}, {31'b0, e_own & s_cpu_req});
            chk({p, "_we"},    {31'b0, we},    {31'b0, e_acc & e_we});
            if (e_acc) chk({p, "_addr"}, addr, e_addr);
            if (e_acc && e_we) chk({p, "_wdata"}, d, e_d);
            if (e_acc && !e_we) begin
                chk({p, "_cpu_rd"}, crd, ref_mem[k][e_addr[9:2]]);
                chk({p, "_cp_rd"},  prd, ref_mem[k][e_addr[9:2]]);
            end
        end
    endtask

    task automatic check_both();
        check_dut(0, b8.owner, b8.cp_gnt, b8.cpu_stall, b8.dm_we, b8.dm_addr, b8.dm_d, b8.cpu_rd, b8.cp_rd);
        check_dut(1, b1.owner, b1.cp_gnt, b1.cpu_stall, b1.dm_we, b1.dm_addr, b1.dm_d, b1.cpu_rd, b1.cp_rd);
        g_own1 = b1.owner;
    endtask

    // Model: the waiting side takes over once the owner idles or it has waited lim cycles.
    task automatic model_step(input int k);
        int          lim, nw;
        logic        acc, wr;
        logic [31:0] a, d;
        lim = (k == 0) ? 8 : 1;
        if (!s_rst) begin
            m_own[k]  = 1'b0;
            m_wait[k] = 0;
        end else begin
            acc = m_own[k] ? s_cp_req  : s_cpu_req;
            wr  = m_own[k] ? s_cp_we   : s_cpu_we;
            a   = m_own[k] ? s_cp_addr : s_cpu_addr;
            d   = m_own[k] ? s_cp_wd   : s_cpu_wd;
            if (acc && wr) ref_mem[k][a[9:2]] = d;
            if (!m_own[k]) begin
                nw = s_cp_req ? m_wait[k] + 1 : 0;
                if (s_cp_req && (!s_cpu_req || nw >= lim)) begin
                    m_own[k] = 1'b1; m_wait[k] = 0;
                end else begin
                    m_wait[k] = nw;
                end
            end else begin
                nw = s_cpu_req ? m_wait[k] + 1 : 0;
                if (!s_cp_req || (s_cpu_req && nw >= lim)) begin
                    m_own[k] = 1'b0; m_wait[k] = 0;
                end else begin
                    m_wait[k] = nw;
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        apply();
        #1;
        check_both();
        @(posedge clk);
        model_step(0);
        model_step(1);
    endtask

    task automatic idle();
        s_cpu_req = 1'b0; s_cpu_we = 1'b0; s_cp_req = 1'b0; s_cp_we = 1'b0;
    endtask

    initial begin
        logic prev;
        int   idx;
        n_checks = 0; n_err = 0;
        mem_clr = 1'b1;
        s_rst = 1'b0; rst = 1'b0;
        s_cpu_addr = 32'h0; s_cpu_wd = 32'h0; s_cp_addr = 32'h0; s_cp_wd = 32'h0;
        idle();
        apply();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = 1'b0; m_wait[k] = 0;
            for (int i = 0; i < 256; i++) ref_mem[k][i] = 32'h0;
        end

        // Reset held with both sides requesting writes: everything quiet.
        s_cpu_req = 1'b1; s_cpu_we = 1'b1; s_cpu_addr = 32'h10; s_cpu_wd = 32'h1111_1111;
        s_cp_req  = 1'b1; s_cp_we  = 1'b1; s_cp_addr  = 32'h20; s_cp_wd  = 32'h2222_2222;
        cycle();
        cycle();
        mem_clr = 1'b0;
        // Release: CPU wins the first cycle while CP2 waits.
        s_rst = 1'b1; s_cpu_we = 1'b0; s_cp_we = 1'b0;
        cycle();
        idle(); cycle();

        // CPU only: write then read back 0x40.
        s_cpu_req = 1'b1; s_cpu_we = 1'b1; s_cpu_addr = 32'h40; s_cpu_wd = 32'hDEAD_BEEF;
        cycle();
        s_cpu_we = 1'b0;
        cycle();
        chk("cpu_readback_40", b8.cpu_rd, 32'hDEAD_BEEF);
        idle(); cycle();

        // CP2 only: four writes at 0x100..0x10C, then release.
        s_cp_req = 1'b1; s_cp_we = 1'b1; s_cp_addr = 32'h100; s_cp_wd = 32'hC0DE_0000;
        cycle();
        for (int i = 0; i < 4; i++) begin
            s_cp_addr = 32'h100 + 32'(i * 4); s_cp_wd = 32'hC0DE_0000 + 32'(i);
            cycle();
        end
        s_cp_req = 1'b0; s_cp_we = 1'b0;
        cycle();
        cycle();
        for (int i = 0; i < 4; i++) begin
            s_cpu_req = 1'b1; s_cpu_addr = 32'h100 + 32'(i * 4);
            cycle();
        end
        idle(); cycle();

        // Full contention with random accesses.
        s_cpu_req = 1'b1; s_cp_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            idx = $urandom_range(0, 63); s_cpu_addr = 32'(idx) << 2;
            idx = $urandom_range(0, 63); s_cp_addr  = 32'(idx) << 2;
            s_cpu_we = 1'($urandom_range(0, 1)); s_cp_we = 1'($urandom_range(0, 1));
            s_cpu_wd = $urandom(); s_cp_wd = $urandom();
            cycle();
        end
        idle(); cycle();

        // Async reset in the third cycle of a CP2 write burst.
        s_cp_req = 1'b1; s_cp_we = 1'b1; s_cp_addr = 32'h300; s_cp_wd = 32'hAAAA_0000;
        cycle();
        for (int i = 0; i < 2; i++) begin
            s_cp_addr = 32'h300 + 32'(i * 4); s_cp_wd = 32'hAAAA_0000 + 32'(i);
            cycle();
        end
        s_cp_addr = 32'h308; s_cp_wd = 32'hAAAA_0002;
        @(negedge clk);
        apply();
        #1;
        check_both();
        #2;
        s_rst = 1'b0; rst = 1'b0;
        #1;
        chk("async_dm_we",  {31'b0, b8.dm_we},  32'h0);
        chk("async_owner",  {31'b0, b8.owner},  32'h0);
        chk("async_cp_gnt", {31'b0, b8.cp_gnt}, 32'h0);
        chk("async_m1_we",  {31'b0, b1.dm_we},  32'h0);
        for (int k = 0; k < 2; k++) begin m_own[k] = 1'b0; m_wait[k] = 0; end
        cycle();
        s_rst = 1'b1; idle();
        s_cpu_req = 1'b1; s_cpu_addr = 32'h308;
        cycle();
        chk("no_partial_write", b8.cpu_rd, 32'h0);
        s_cpu_addr = 32'h304;
        cycle();
        idle(); cycle();

        // Preload 0x200, then both sides read it under full contention.
        s_cpu_req = 1'b1; s_cpu_we = 1'b1; s_cpu_addr = 32'h200; s_cpu_wd = 32'h5A5A_1234;
        cycle();
        prev = g_own1;
        s_cpu_we = 1'b0; s_cp_req = 1'b1; s_cp_we = 1'b0; s_cp_addr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i > 0) chk("m1_toggle", {31'b0, g_own1}, {31'b0, ~prev});
            prev = g_own1;
            chk("m1_shared_rd", b1.cpu_rd, 32'h5A5A_1234);
        end
        idle(); cycle();

        // Random mixed traffic.
        for (int i = 0; i < 60; i++) begin
            s_cpu_req = 1'($urandom_range(0, 1)); s_cp_req = 1'($urandom_range(0, 1));
            s_cpu_we  = 1'($urandom_range(0, 1)); s_cp_we  = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 63); s_cpu_addr = 32'(idx) << 2;
            idx = $urandom_range(0, 63); s_cp_addr  = 32'(idx) << 2;
            s_cpu_wd = $urandom(); s_cp_wd = $urandom();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
